// File: rtl/seq_alu.sv
// Execute-stage ALU: data-processing ops registered in 1 cycle; MUL/MLA via WIDTH-step shift-add, Done after WIDTH+1 cycles.
// Busy is high while a multiply iterates and Start is dropped (not queued) then; Start is accepted on the Done cycle.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Mode,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    input  logic [WIDTH-1:0] Src_Acc,
    input  logic             C_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin, arith;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] dp_res_d;
    logic [3:0]       dp_flags_d;
    logic [WIDTH-1:0] acc_d;
    logic             last_step;

    // Every arithmetic op is one shared adder; subtraction is X + ~Y + cin.
    always_comb begin
        add_x   = Src_A;
        add_y   = Src_B;
        add_cin = 1'b0;
        arith   = 1'b0;
        case (ALUControl)
            4'b0010, 4'b1010: begin add_y = ~Src_B; add_cin = 1'b1; arith = 1'b1; end
            4'b0011:          begin add_x = Src_B; add_y = ~Src_A; add_cin = 1'b1; arith = 1'b1; end
            4'b0100, 4'b1011: begin arith = 1'b1; end
            4'b0101:          begin add_cin = C_in; arith = 1'b1; end
            4'b0110:          begin add_y = ~Src_B; add_cin = C_in; arith = 1'b1; end
            4'b0111:          begin add_x = Src_B; add_y = ~Src_A; add_cin = C_in; arith = 1'b1; end
            default:          ;
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

        case (ALUControl)
            4'b0000, 4'b1000: dp_res_d = Src_A & Src_B;
            4'b0001, 4'b1001: dp_res_d = Src_A ^ Src_B;
            4'b1100:          dp_res_d = Src_A | Src_B;
            4'b1101:          dp_res_d = Src_B;
            4'b1110:          dp_res_d = Src_A & ~Src_B;
            4'b1111:          dp_res_d = ~Src_B;
            default:          dp_res_d = add_sum[WIDTH-1:0];
        endcase

        dp_flags_d[3] = dp_res_d[WIDTH-1];
        dp_flags_d[2] = (dp_res_d == '0);
        dp_flags_d[1] = arith & add_sum[WIDTH];
        dp_flags_d[0] = arith & (add_x[WIDTH-1] == add_y[WIDTH-1])
                              & (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    end

    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start && !Mode) begin
                        result_q <= dp_res_d;
                        flags_q  <= dp_flags_d;
                        done_q   <= 1'b1;
                    end else if (Start && Mode) begin
                        mcand_q  <= Src_A;
                        mplier_q <= Src_B;
                        acc_q    <= ALUControl[0] ? Src_Acc : '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // The final step writes the result directly so Done follows Busy with no gap.
                    if (last_step) begin
                        result_q <= acc_d;
                        flags_q  <= {acc_d[WIDTH-1], (acc_d == '0), 2'b00};
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;

endmodule
